store_align_unit: RTL and testbench
===================================

Name: store_align_unit

Overview:
Store-side counterpart to the load extension path in the single-cycle core's data-memory interface. Accepts one store request per handshake: byte address, rs2 data (RD2) and StoreSRC width code. Drives a word-addressed data memory with lane-aligned write data and byte enables. A misaligned halfword or word store is split into two aligned bus beats by a small FSM.

Parameters:
ADDR_W, 32, byte-address width; memory address outputs are word-aligned (bits [1:0] = 0)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
req_valid  input  1  store request present
req_ready  output  1  unit can accept a request (high only in IDLE)
Addr  input  ADDR_W  byte address of store
RD2  input  32  store source data (rs2)
StoreSRC  input  3  width code: 000 = SB, 001 = SH, 010 = SW; all other codes are illegal
mem_we  output  1  write beat valid
mem_addr  output  ADDR_W  word-aligned beat address
mem_wdata  output  32  lane-aligned write data; disabled lanes = 0
mem_be  output  4  byte enables; bit i = byte lane i (bits [8i+7:8i])
mem_ack  input  1  memory accepts the beat in a cycle where mem_we && mem_ack
done  output  1  one-cycle pulse: request fully written
misalign  output  1  one-cycle pulse with done when the request was split
err  output  1  one-cycle pulse: illegal StoreSRC; request dropped

Behaviour:
- Reset values: state IDLE; mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0, done = 0, misalign = 0, err = 0. req_ready = (state == IDLE), so it is 1 in the first cycle after reset.
- Reset mid-operation: returns to IDLE next edge. Any pending beat is abandoned. No done is issued. A beat 0 already acked stays written.
- FSM states: IDLE, BEAT0, BEAT1. All outputs are registered except req_ready.
- IDLE, on req_valid && req_ready:
  - Capture Addr, RD2 and StoreSRC.
  - Legal code: next state BEAT0, with the beat-0 outputs present on the next cycle.
  - Illegal code: stay in IDLE, pulse err the next cycle, no memory beat.
- BEAT0/BEAT1: mem_we = 1, and mem_addr, mem_wdata and mem_be are held stable until mem_ack. Wait states are unbounded.
  - Ack in BEAT0 with split: go to BEAT1.
  - Ack in BEAT0 without split, or ack in BEAT1: go to IDLE with mem_we = 0. done (and misalign if split) pulses in that first IDLE cycle.
- Latency: aligned store with zero wait states: accepted at cycle 0, beat at cycle 1 (ack), done at cycle 2. A new request may be accepted in the done cycle.
- Alignment, with off = Addr[1:0] and A = {Addr[ADDR_W-1:2], 2'b00}:
  - SB: single beat at A. be = 0001 << off. Byte RD2[7:0] placed in lane off.
  - SH, off <= 2: single beat. be = 0011 << off. Data = RD2[15:0] << 8*off.
  - SH, off = 3: split.
    - Beat 0 at A: be = 1000, lane 3 = RD2[7:0].
    - Beat 1 at A+4: be = 0001, lane 0 = RD2[15:8].
  - SW, off = 0: single beat, be = 1111, data = RD2.
  - SW, off != 0: split.
    - Beat 0 at A: be = (1111 << off)[3:0], data = RD2 << 8*off.
    - Beat 1 at A+4: be = 1111 >> (4 - off), data = RD2 >> 8*(4 - off).
- Address wrap: A+4 is computed modulo 2^ADDR_W, so 0xFFFFFFFC + 4 = 0x00000000.
- Little-endian throughout. Lanes outside mem_be are always 0 in mem_wdata.
- req_valid while busy is ignored (no capture). The requester must hold its request until req_ready.

Test Plan:
- SB Addr=0x103, RD2=0xAABBCCDD, mem_ack tied 1 -> single beat: mem_addr=0x100, be=1000, wdata=0xDD000000; done at cycle 2, misalign=0.
- SH Addr=0x202, RD2=0x1234BEEF -> single beat: mem_addr=0x200, be=1100, wdata=0xBEEF0000.
- SW Addr=0x301, RD2=0x11223344 -> beat 0: addr 0x300, be=1110, wdata=0x22334400; beat 1: addr 0x304, be=0001, wdata=0x00000011; done and misalign pulse together.
- SH Addr=0xFFFFFFFF, RD2=0x0000A55A, mem_ack low for 3 cycles on each beat -> beat 0: addr 0xFFFFFFFC, be=1000, wdata=0x5A000000; beat 1: addr 0x00000000, be=0001, wdata=0x000000A5; outputs stable during waits.
- StoreSRC=011 -> err pulse one cycle, mem_we never asserted, req_ready stays 1; then SW Addr=0x0 -> be=1111 accepted normally.
- rst asserted during beat-1 wait of a split SW -> next cycle mem_we=0, state IDLE, req_ready=1, no done pulse.

Source files
------------

// File: rtl/store_align_unit.sv
// Store-side alignment unit: places rs2 data into byte lanes of a word-addressed
// memory and splits misaligned halfword/word stores into two aligned beats.
module store_align_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       RD2,
    input  logic [2:0]        StoreSRC,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    output logic              done,
    output logic              misalign,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT0,
        S_BEAT1
    } state_t;

    localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

    state_t            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic              r_done;
    logic              r_mis;
    logic              r_err;
    logic              r_split;
    logic [ADDR_W-1:0] r_b1_addr;
    logic [31:0]       r_b1_wdata;
    logic [3:0]        r_b1_be;

    state_t            w_state_n;
    logic              w_we_n;
    logic [ADDR_W-1:0] w_addr_n;
    logic [31:0]       w_wdata_n;
    logic [3:0]        w_be_n;
    logic              w_done_n;
    logic              w_mis_n;
    logic              w_err_n;
    logic              w_split_n;
    logic [ADDR_W-1:0] w_b1_addr_n;
    logic [31:0]       w_b1_wdata_n;
    logic [3:0]        w_b1_be_n;

    logic [1:0]        w_off;
    logic [ADDR_W-1:0] w_base;
    logic [3:0]        w_mask;
    logic [31:0]       w_mdata;
    logic              w_legal;
    logic [7:0]        w_be8;
    logic [63:0]       w_data64;

    // Shift into an 8-lane window: low half is beat 0, high half spills into beat 1.
    always_comb begin
        w_off   = Addr[1:0];
        w_base  = {Addr[ADDR_W-1:2], 2'b00};
        w_mask  = 4'b0000;
        w_mdata = 32'h0;
        w_legal = 1'b0;
        case (StoreSRC)
            3'b000: begin
                w_mask  = 4'b0001;
                w_mdata = {24'h0, RD2[7:0]};
                w_legal = 1'b1;
            end
            3'b001: begin
                w_mask  = 4'b0011;
                w_mdata = {16'h0, RD2[15:0]};
                w_legal = 1'b1;
            end
            3'b010: begin
                w_mask  = 4'b1111;
                w_mdata = RD2;
                w_legal = 1'b1;
            end
            default: ;
        endcase
        w_be8    = {4'b0000, w_mask} << w_off;
        w_data64 = {32'h0, w_mdata} << {w_off, 3'b000};
    end

    always_comb begin
        w_state_n    = r_state;
        w_we_n       = r_we;
        w_addr_n     = r_addr;
        w_wdata_n    = r_wdata;
        w_be_n       = r_be;
        w_done_n     = 1'b0;
        w_mis_n      = 1'b0;
        w_err_n      = 1'b0;
        w_split_n    = r_split;
        w_b1_addr_n  = r_b1_addr;
        w_b1_wdata_n = r_b1_wdata;
        w_b1_be_n    = r_b1_be;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_legal) begin
                        w_state_n    = S_BEAT0;
                        w_we_n       = 1'b1;
                        w_addr_n     = w_base;
                        w_wdata_n    = w_data64[31:0];
                        w_be_n       = w_be8[3:0];
                        w_split_n    = (w_be8[7:4] != 4'b0000);
                        w_b1_addr_n  = w_base + WORD;
                        w_b1_wdata_n = w_data64[63:32];
                        w_b1_be_n    = w_be8[7:4];
                    end else begin
                        w_err_n = 1'b1;
                    end
                end
            end
            S_BEAT0: begin
                if (mem_ack) begin
                    if (r_split) begin
                        w_state_n = S_BEAT1;
                        w_addr_n  = r_b1_addr;
                        w_wdata_n = r_b1_wdata;
                        w_be_n    = r_b1_be;
                    end else begin
                        w_state_n = S_IDLE;
                        w_we_n    = 1'b0;
                        w_addr_n  = '0;
                        w_wdata_n = 32'h0;
                        w_be_n    = 4'b0000;
                        w_done_n  = 1'b1;
                    end
                end
            end
            S_BEAT1: begin
                if (mem_ack) begin
                    w_state_n = S_IDLE;
                    w_we_n    = 1'b0;
                    w_addr_n  = '0;
                    w_wdata_n = 32'h0;
                    w_be_n    = 4'b0000;
                    w_done_n  = 1'b1;
                    w_mis_n   = 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_we_n    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_be       <= 4'b0000;
            r_done     <= 1'b0;
            r_mis      <= 1'b0;
            r_err      <= 1'b0;
            r_split    <= 1'b0;
            r_b1_addr  <= '0;
            r_b1_wdata <= 32'h0;
            r_b1_be    <= 4'b0000;
        end else begin
            r_state    <= w_state_n;
            r_we       <= w_we_n;
            r_addr     <= w_addr_n;
            r_wdata    <= w_wdata_n;
            r_be       <= w_be_n;
            r_done     <= w_done_n;
            r_mis      <= w_mis_n;
            r_err      <= w_err_n;
            r_split    <= w_split_n;
            r_b1_addr  <= w_b1_addr_n;
            r_b1_wdata <= w_b1_wdata_n;
            r_b1_be    <= w_b1_be_n;
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;
    assign done      = r_done;
    assign misalign  = r_mis;
    assign err       = r_err;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: lane placement, split beats,
// wait states, address wrap, illegal codes and mid-operation reset.
module tb_store_align_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] Addr;
    logic [31:0] RD2;
    logic [2:0]  StoreSRC;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        done;
    logic        misalign;
    logic        err;

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    store_align_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .Addr      (Addr),
        .RD2       (RD2),
        .StoreSRC  (StoreSRC),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .done      (done),
        .misalign  (misalign),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] s);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready", {63'h0, req_ready}, 64'h1);
        req_valid = 1'b1;
        Addr      = a;
        RD2       = d;
        StoreSRC  = s;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Checks a beat (held stable across waits), then acks it.
    task automatic beat(input string tag, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d,
                        input int waits, output int n);
        n = 0;
        @(negedge clk);
        while (!mem_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_we"}, {63'h0, mem_we}, 64'h1);
        chk({tag, "_done0"}, {63'h0, done}, 64'h0);
        for (int i = 0; i <= waits; i++) begin
            chk({tag, "_addr"}, {32'h0, mem_addr}, {32'h0, a});
            chk({tag, "_be"}, {60'h0, mem_be}, {60'h0, be});
            chk({tag, "_data"}, {32'h0, mem_wdata}, {32'h0, d});
            chk({tag, "_rdy"}, {63'h0, req_ready}, 64'h0);
            if (i < waits) @(negedge clk);
        end
        mem_ack = 1'b1;
        @(posedge clk);
        #1 mem_ack = 1'b0;
    endtask

    task automatic fin(input string tag, input logic mis);
        @(negedge clk);
        chk({tag, "_done"}, {63'h0, done}, 64'h1);
        chk({tag, "_mis"}, {63'h0, misalign}, {63'h0, mis});
        chk({tag, "_weoff"}, {63'h0, mem_we}, 64'h0);
        chk({tag, "_rdy"}, {63'h0, req_ready}, 64'h1);
        @(negedge clk);
        chk({tag, "_done1"}, {63'h0, done}, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        Addr      = 32'h0;
        RD2       = 32'h0;
        StoreSRC  = 3'b000;
        mem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_we", {63'h0, mem_we}, 64'h0);
        chk("rst_addr", {32'h0, mem_addr}, 64'h0);
        chk("rst_data", {32'h0, mem_wdata}, 64'h0);
        chk("rst_be", {60'h0, mem_be}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_err", {63'h0, err}, 64'h0);
        chk("rst_rdy", {63'h0, req_ready}, 64'h1);

        send(32'h103, 32'hAABBCCDD, 3'b000);
        beat("sb", 32'h100, 4'b1000, 32'hDD000000, 0, lat);
        chk("sb_lat", 64'(lat), 64'h0);
        fin("sb", 1'b0);

        send(32'h202, 32'h1234BEEF, 3'b001);
        beat("sh", 32'h200, 4'b1100, 32'hBEEF0000, 0, lat);
        fin("sh", 1'b0);

        send(32'h301, 32'h11223344, 3'b010);
        beat("sw0", 32'h300, 4'b1110, 32'h22334400, 0, lat);
        beat("sw1", 32'h304, 4'b0001, 32'h00000011, 0, lat);
        fin("sw", 1'b1);

        send(32'hFFFFFFFF, 32'h0000A55A, 3'b001);
        beat("wr0", 32'hFFFFFFFC, 4'b1000, 32'h5A000000, 3, lat);
        beat("wr1", 32'h00000000, 4'b0001, 32'h000000A5, 3, lat);
        fin("wr", 1'b1);

        send(32'h40, 32'hDEADBEEF, 3'b011);
        @(negedge clk);
        chk("il_err", {63'h0, err}, 64'h1);
        chk("il_we", {63'h0, mem_we}, 64'h0);
        chk("il_rdy", {63'h0, req_ready}, 64'h1);
        @(negedge clk);
        chk("il_err1", {63'h0, err}, 64'h0);
        chk("il_we1", {63'h0, mem_we}, 64'h0);

        send(32'h0, 32'hCAFEF00D, 3'b010);
        beat("swa", 32'h0, 4'b1111, 32'hCAFEF00D, 0, lat);
        fin("swa", 1'b0);

        send(32'h1, 32'h00000077, 3'b000);
        beat("sb1", 32'h0, 4'b0010, 32'h00007700, 1, lat);
        fin("sb1", 1'b0);

        send(32'h3, 32'h0000ABCD, 3'b001);
        beat("sh30", 32'h0, 4'b1000, 32'hCD000000, 0, lat);
        beat("sh31", 32'h4, 4'b0001, 32'h000000AB, 0, lat);
        fin("sh3", 1'b1);

        send(32'h12, 32'h55667788, 3'b010);
        beat("rs0", 32'h10, 4'b1100, 32'h77880000, 0, lat);
        @(negedge clk);
        chk("rs1_we", {63'h0, mem_we}, 64'h1);
        chk("rs1_addr", {32'h0, mem_addr}, 64'h14);
        chk("rs1_be", {60'h0, mem_be}, 64'h3);
        chk("rs1_data", {32'h0, mem_wdata}, 64'h5566);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rs_we", {63'h0, mem_we}, 64'h0);
        chk("rs_rdy", {63'h0, req_ready}, 64'h1);
        chk("rs_done", {63'h0, done}, 64'h0);
        @(negedge clk);
        chk("rs_done1", {63'h0, done}, 64'h0);
        chk("rs_we1", {63'h0, mem_we}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
